// File: rtl/GLOBAL_PARAM.sv
// Shared parameters and types for the fully-connected layer scheduler.
// Holds the scheduler state encoding, datapath widths and the helper that
// maps a (output tile, input tile) position onto the count-memory address.
package GLOBAL_PARAM;

    localparam int bw    = 8;
    localparam int BATCH = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_BUF,
        ISSUE,
        WAIT_AGU,
        NEXT
    } fc_sched_state_t;

    // Row-major tile address: o * in_tiles + i, kept at the full 16-bit product width.
    function automatic logic [15:0] tile_addr(input logic [bw-1:0] o,
                                              input logic [bw-1:0] i,
                                              input logic [bw-1:0] n);
        return ({8'd0, o} * {8'd0, n}) + {8'd0, i};
    endfunction

endpackage

// File: rtl/fc_sched_if.sv
// Tile-loop bus between the scheduler FSM and its 2-D tile counter.
// The scheduler owns clear/inc and the loop bounds; the counter reports the
// current position and whether it is sitting on the last tile of the layer.
interface fc_sched_if;

    logic       clear;
    logic       inc;
    logic       last;
    logic [7:0] in_tiles;
    logic [7:0] out_tiles;
    logic [7:0] in_idx;
    logic [7:0] out_idx;

    modport master (
        output clear, inc, in_tiles, out_tiles,
        input  last, in_idx, out_idx
    );

    modport slave (
        input  clear, inc, in_tiles, out_tiles,
        output last, in_idx, out_idx
    );

endinterface

// File: rtl/fc_tile_cnt.sv
// Two-dimensional wrapping tile counter: the input-tile index runs fastest and
// carries into the output-tile index; both wrap to zero after the last tile.
module fc_tile_cnt (
    input  logic        clk,
    input  logic        rst,
    fc_sched_if.slave   tile
);

    logic [7:0] in_q, in_d;
    logic [7:0] out_q, out_d;
    logic       in_wrap;
    logic       out_wrap;

    assign in_wrap      = (in_q == tile.in_tiles - 8'd1);
    assign out_wrap     = (out_q == tile.out_tiles - 8'd1);
    assign tile.last    = in_wrap && out_wrap;
    assign tile.in_idx  = in_q;
    assign tile.out_idx = out_q;

    // Next position: clear wins, otherwise step i and carry into o on wrap.
    always_comb begin
        in_d  = in_q;
        out_d = out_q;
        if (tile.clear) begin
            in_d  = 8'd0;
            out_d = 8'd0;
        end else if (tile.inc) begin
            if (in_wrap) begin
                in_d  = 8'd0;
                out_d = out_wrap ? 8'd0 : out_q + 8'd1;
            end else begin
                in_d = in_q + 8'd1;
            end
        end
    end

    // Position registers, zeroed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q  <= 8'd0;
            out_q <= 8'd0;
        end else begin
            in_q  <= in_d;
            out_q <= out_d;
        end
    end

endmodule

// File: rtl/fc_sched.sv
// Fully-connected layer tile scheduler.
// Walks output tiles (outer) by input tiles (inner); for each tile it reads the
// index count, waits for the buffers, kicks the AGU when there is work, then
// frees the buffers and moves on. Define FC_SCHED_PERF_EN to add the busy and
// stall performance counters.
module fc_sched
    import GLOBAL_PARAM::*;
#(
    parameter int CNT_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [1:0]            conf_mode,
    input  logic [7:0]            conf_in_tiles,
    input  logic [7:0]            conf_out_tiles,
    output logic [CNT_ADDR_W-1:0] cnt_rd_addr,
    input  logic [7:0]            cnt_rd_data,
    input  logic                  buf_ready,
    output logic                  buf_release,
    output logic                  agu_start,
    input  logic                  agu_done,
    output logic [1:0]            agu_conf_mode,
    output logic [7:0]            agu_conf_idx_cnt,
    output logic                  agu_conf_is_new,
    output logic [7:0]            tile_in_idx,
    output logic [7:0]            tile_out_idx
`ifdef FC_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_busy_cyc,
    output logic [31:0]           perf_stall_cyc
`endif
);

    fc_sched_state_t state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [7:0]      in_tiles_q, in_tiles_d;
    logic [7:0]      out_tiles_q, out_tiles_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            fetch_ph_q, fetch_ph_d;
    logic            skip_q, skip_d;
    logic [1:0]      agu_mode_q, agu_mode_d;
    logic [7:0]      agu_idx_q, agu_idx_d;
    logic            agu_new_q, agu_new_d;
    logic            tile_clear;
    logic            tile_inc;
    logic            accept;

    fc_sched_if tile_bus ();

    fc_tile_cnt u_tile_cnt (
        .clk  (clk),
        .rst  (rst),
        .tile (tile_bus)
    );

    assign tile_bus.clear     = tile_clear;
    assign tile_bus.inc       = tile_inc;
    assign tile_bus.in_tiles  = in_tiles_q;
    assign tile_bus.out_tiles = out_tiles_q;

    assign accept = (state_q == IDLE) && start
                    && (conf_in_tiles != 8'd0) && (conf_out_tiles != 8'd0);

    assign done             = (state_q == IDLE);
    assign agu_start        = (state_q == ISSUE);
    assign buf_release      = (state_q == NEXT);
    assign agu_conf_mode    = agu_mode_q;
    assign agu_conf_idx_cnt = agu_idx_q;
    assign agu_conf_is_new  = agu_new_q;
    assign tile_in_idx      = tile_bus.in_idx;
    assign tile_out_idx     = tile_bus.out_idx;
    assign cnt_rd_addr      = CNT_ADDR_W'(tile_addr(tile_bus.out_idx, tile_bus.in_idx, in_tiles_q));

    // Next-state logic: FETCH spends one cycle on the address and one capturing
    // the read data; the first WAIT_AGU cycle skips the stale AGU done level.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        in_tiles_d  = in_tiles_q;
        out_tiles_d = out_tiles_q;
        cnt_d       = cnt_q;
        fetch_ph_d  = fetch_ph_q;
        skip_d      = skip_q;
        agu_mode_d  = agu_mode_q;
        agu_idx_d   = agu_idx_q;
        agu_new_d   = agu_new_q;
        tile_clear  = 1'b0;
        tile_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d      = conf_mode;
                    in_tiles_d  = conf_in_tiles;
                    out_tiles_d = conf_out_tiles;
                    tile_clear  = 1'b1;
                    fetch_ph_d  = 1'b0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    fetch_ph_d = 1'b0;
                    cnt_d      = cnt_rd_data;
                    state_d    = WAIT_BUF;
                end
            end
            WAIT_BUF: begin
                if (buf_ready) begin
                    if (cnt_q != 8'd0) begin
                        agu_mode_d = mode_q;
                        agu_idx_d  = cnt_q;
                        agu_new_d  = (tile_bus.in_idx == 8'd0);
                        state_d    = ISSUE;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            ISSUE: begin
                skip_d  = 1'b1;
                state_d = WAIT_AGU;
            end
            WAIT_AGU: begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (agu_done) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                tile_inc = 1'b1;
                state_d  = tile_bus.last ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and configuration registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 2'd0;
            in_tiles_q  <= 8'd0;
            out_tiles_q <= 8'd0;
            cnt_q       <= 8'd0;
            fetch_ph_q  <= 1'b0;
            skip_q      <= 1'b0;
            agu_mode_q  <= 2'd0;
            agu_idx_q   <= 8'd0;
            agu_new_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            in_tiles_q  <= in_tiles_d;
            out_tiles_q <= out_tiles_d;
            cnt_q       <= cnt_d;
            fetch_ph_q  <= fetch_ph_d;
            skip_q      <= skip_d;
            agu_mode_q  <= agu_mode_d;
            agu_idx_q   <= agu_idx_d;
            agu_new_q   <= agu_new_d;
        end
    end

`ifdef FC_SCHED_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;

    assign perf_busy_cyc  = perf_busy_q;
    assign perf_stall_cyc = perf_stall_q;

    // Saturating busy/stall counters, restarted by each accepted layer start.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            perf_busy_q  <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (!done && (perf_busy_q != 32'hFFFF_FFFF)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if ((state_q == WAIT_BUF) && !buf_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc_sched.sv
// Self-checking bench for fc_sched: a tile-level scoreboard predicts every AGU
// issue and buffer release from the layer configuration and count memory.
module tb_fc_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic        done;
    logic [1:0]  confMode;
    logic [7:0]  confIn;
    logic [7:0]  confOut;
    logic [15:0] cntRdAddr;
    logic [7:0]  cntRdData;
    logic        bufReady;
    logic        bufRelease;
    logic        aguStart;
    logic        aguDone;
    logic [1:0]  aguConfMode;
    logic [7:0]  aguConfIdx;
    logic        aguConfNew;
    logic [7:0]  tileIn;
    logic [7:0]  tileOut;
`ifdef FC_SCHED_PERF_EN
    logic [31:0] perfBusy;
    logic [31:0] perfStall;
`endif

    typedef struct {
        int         o;
        int         i;
        logic       isNew;
        logic [7:0] idx;
        logic [1:0] md;
    } issT;

    issT         issQ[$];
    int          relQ[$];
    logic [7:0]  cntMem [0:255];
    int          aguCnt;
    int          vecCount;
    int          errCount;
    int          startPulses;
    int          newPulses;
    int          relPulses;
    logic [1:0]  lastMode;
    logic [7:0]  lastIdx;
    logic        lastNew;

    fc_sched_if tcBus ();

    fc_sched #(.CNT_ADDR_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .done             (done),
        .conf_mode        (confMode),
        .conf_in_tiles    (confIn),
        .conf_out_tiles   (confOut),
        .cnt_rd_addr      (cntRdAddr),
        .cnt_rd_data      (cntRdData),
        .buf_ready        (bufReady),
        .buf_release      (bufRelease),
        .agu_start        (aguStart),
        .agu_done         (aguDone),
        .agu_conf_mode    (aguConfMode),
        .agu_conf_idx_cnt (aguConfIdx),
        .agu_conf_is_new  (aguConfNew),
`ifdef FC_SCHED_PERF_EN
        .perf_busy_cyc    (perfBusy),
        .perf_stall_cyc   (perfStall),
`endif
        .tile_in_idx      (tileIn),
        .tile_out_idx     (tileOut)
    );

    fc_tile_cnt uTc (
        .clk  (clk),
        .rst  (rst),
        .tile (tcBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count memory with one-cycle read latency.
    always @(posedge clk) cntRdData <= cntMem[cntRdAddr[7:0]];

    // AGU model: done drops on start and returns 7 cycles later.
    always @(posedge clk) begin
        if (rst) begin
            aguDone <= 1'b1;
            aguCnt  <= 0;
        end else if (aguStart) begin
            aguDone <= 1'b0;
            aguCnt  <= 7;
        end else if (aguCnt != 0) begin
            aguCnt <= aguCnt - 1;
            if (aguCnt == 1) aguDone <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard compare on every non-reset cycle.
    always @(negedge clk) begin
        issT e;
        if (!rst) begin
            if (aguStart) begin
                startPulses++;
                if (aguConfNew) newPulses++;
                if (issQ.size() == 0) begin
                    checkOutput("agu_start with no tile pending", 32'(aguStart), 32'd0);
                end else begin
                    e = issQ.pop_front();
                    checkOutput("issueTileOut", 32'(tileOut), e.o);
                    checkOutput("issueTileIn", 32'(tileIn), e.i);
                    checkOutput("issueIsNew", 32'(aguConfNew), 32'(e.isNew));
                    checkOutput("issueIdxCnt", 32'(aguConfIdx), 32'(e.idx));
                    checkOutput("issueMode", 32'(aguConfMode), 32'(e.md));
                    lastMode = e.md;
                    lastIdx  = e.idx;
                    lastNew  = e.isNew;
                end
            end else begin
                checkOutput("confHold", {21'd0, aguConfMode, aguConfIdx, aguConfNew},
                            {21'd0, lastMode, lastIdx, lastNew});
            end
            if (bufRelease) begin
                relPulses++;
                if (relQ.size() == 0) begin
                    checkOutput("buf_release with no tile pending", 32'(bufRelease), 32'd0);
                end else begin
                    checkOutput("releaseTile", 32'(tileOut) * 256 + 32'(tileIn), relQ.pop_front());
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Done"}, 32'(done), 32'd1);
        checkOutput({tag, "AguStart"}, 32'(aguStart), 32'd0);
        checkOutput({tag, "BufRelease"}, 32'(bufRelease), 32'd0);
        checkOutput({tag, "AguConf"}, {21'd0, aguConfMode, aguConfIdx, aguConfNew}, 32'd0);
        checkOutput({tag, "TileIdx"}, {16'd0, tileOut, tileIn}, 32'd0);
        checkOutput({tag, "CntAddr"}, 32'(cntRdAddr), 32'd0);
    endtask

    // Runs one layer; scenario 1 adds stray starts, 2 parks before tile (1,0),
    // 3 resets inside WAIT_AGU of tile (1,1).
    task automatic applyStimulus(input int inT, input int outT, input logic [1:0] md, input int scenario);
        int stallCnt;
        int rstCnt;
        int startsAtStall;
        bit stallDone;
        bit timedOut;
        stallCnt = 0;
        rstCnt = -1;
        startsAtStall = 0;
        stallDone = 0;
        timedOut = 1;
        for (int o = 0; o < outT; o++) begin
            for (int i = 0; i < inT; i++) begin
                issT e;
                int a;
                a = o * inT + i;
                relQ.push_back(o * 256 + i);
                if (cntMem[a] != 8'd0) begin
                    e.o = o;
                    e.i = i;
                    e.isNew = (i == 0);
                    e.idx = cntMem[a];
                    e.md = md;
                    issQ.push_back(e);
                end
            end
        end
        startPulses = 0;
        newPulses = 0;
        relPulses = 0;
        @(negedge clk);
        confMode = md;
        confIn = inT[7:0];
        confOut = outT[7:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        confIn = 8'hA5;
        confOut = 8'h5A;
        confMode = ~md;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                timedOut = 0;
                break;
            end
            if (scenario == 1) begin
                if (c == 10) begin
                    start = 1'b1;
                    confIn = 8'd1;
                    confOut = 8'd1;
                end
                if (bufRelease && tileOut == 8'(outT - 1) && tileIn == 8'(inT - 1)) start = 1'b1;
            end
            if (scenario == 2) begin
                if (stallCnt > 0) begin
                    stallCnt--;
                    if (stallCnt == 0) begin
                        checkOutput("startsWhileParked", startPulses, startsAtStall);
                        bufReady = 1'b1;
                    end
                end else if (!stallDone && bufRelease && tileOut == 8'd0 && tileIn == 8'(inT - 1)) begin
                    bufReady = 1'b0;
                    stallCnt = 23;
                    stallDone = 1;
                    startsAtStall = startPulses;
                end
            end
            if (scenario == 3) begin
                if (rstCnt > 0) begin
                    rstCnt--;
                    if (rstCnt == 0) begin
                        rst = 1'b1;
                        issQ.delete();
                        relQ.delete();
                        lastMode = 2'd0;
                        lastIdx = 8'd0;
                        lastNew = 1'b0;
                        @(negedge clk);
                        checkResetOutputs("midReset");
                        rst = 1'b0;
                        timedOut = 0;
                        break;
                    end
                end else if (rstCnt < 0 && aguStart && tileOut == 8'd1 && tileIn == 8'd1) begin
                    rstCnt = 2;
                end
            end
        end
        checkOutput("layerTimeout", 32'(timedOut), 32'd0);
        checkOutput("issuesLeft", issQ.size(), 0);
        checkOutput("releasesLeft", relQ.size(), 0);
    endtask

    initial begin
        int relBefore;
        vecCount = 0;
        errCount = 0;
        startPulses = 0;
        newPulses = 0;
        relPulses = 0;
        lastMode = 2'd0;
        lastIdx = 8'd0;
        lastNew = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        bufReady = 1'b1;
        confMode = 2'd0;
        confIn = 8'd0;
        confOut = 8'd0;
        tcBus.clear = 1'b0;
        tcBus.inc = 1'b0;
        tcBus.in_tiles = 8'd3;
        tcBus.out_tiles = 8'd2;
        for (int a = 0; a < 256; a++) cntMem[a] = 8'd0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        // Standalone tile counter: 3 input by 2 output tiles, wrap after (1,2).
        tcBus.clear = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            tcBus.clear = 1'b0;
            checkOutput("tileCntPos", {16'd0, tcBus.out_idx, tcBus.in_idx}, ((k / 3) % 2) * 256 + (k % 3));
            checkOutput("tileCntLast", 32'(tcBus.last), (k == 5) ? 32'd1 : 32'd0);
            tcBus.inc = 1'b1;
        end
        tcBus.inc = 1'b0;

        // Plain 2x3 layer with a stray start mid-layer and one on the final NEXT.
        for (int a = 0; a < 6; a++) cntMem[a] = 8'd5;
        applyStimulus(2, 3, 2'd2, 1);
        checkOutput("layer1Starts", startPulses, 6);
        checkOutput("layer1New", newPulses, 3);
        checkOutput("layer1Releases", relPulses, 6);
        repeat (10) @(negedge clk);
        checkOutput("doneAfterFinalStart", 32'(done), 32'd1);
        checkOutput("noSecondLayer", startPulses, 6);
`ifdef FC_SCHED_PERF_EN
        checkOutput("layer1PerfStall", perfStall, 32'd0);
`endif

        // Zero count on tile (0,1) skips its AGU issue but still releases.
        cntMem[0] = 8'd3; cntMem[1] = 8'd0; cntMem[2] = 8'd9;
        cntMem[3] = 8'd1; cntMem[4] = 8'd255; cntMem[5] = 8'd7;
        applyStimulus(2, 3, 2'd1, 0);
        checkOutput("layer2Starts", startPulses, 5);
        checkOutput("layer2Releases", relPulses, 6);

        // Buffers withheld for 20 WAIT_BUF cycles before tile (1,0).
        for (int a = 0; a < 6; a++) cntMem[a] = 8'd2;
        applyStimulus(3, 2, 2'd3, 2);
        checkOutput("layer3Starts", startPulses, 6);
`ifdef FC_SCHED_PERF_EN
        checkOutput("layer3PerfStall", perfStall, 32'd20);
        checkOutput("layer3BusyAboveStall", 32'(perfBusy > perfStall), 32'd1);
`endif

        // Zero tile counts: start must be ignored.
        startPulses = 0;
        @(negedge clk);
        confIn = 8'd0;
        confOut = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        confIn = 8'd3;
        confOut = 8'd0;
        start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput("zeroTileDone", 32'(done), 32'd1);
            checkOutput("zeroTileAddr", 32'(cntRdAddr), 32'd0);
        end
        checkOutput("zeroTileStarts", startPulses, 0);

        // Reset inside WAIT_AGU of tile (1,1), then restart from (0,0).
        for (int a = 0; a < 6; a++) cntMem[a] = 8'd4;
        applyStimulus(2, 3, 2'd2, 3);
        relBefore = relPulses;
        repeat (10) @(negedge clk);
        checkOutput("releaseAfterReset", relPulses, relBefore);
        checkOutput("doneAfterReset", 32'(done), 32'd1);
        applyStimulus(2, 1, 2'd1, 0);
        checkOutput("restartStarts", startPulses, 2);
        checkOutput("restartNew", newPulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
